nexys4ddr_display_mux: RTL

//  Parametrised multiplexed seven-segment driver, successor to the fixed 8-digit board display.

---
 rtl/nexys4ddr_display_mux.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/nexys4ddr_display_mux.sv
`default_nettype none
// ============================================================================
// Module : nexys4ddr_display_mux
// Multiplexed seven-segment scanner with shadowed per-digit data, hex/raw
// mode, blanking and PWM brightness, driven by a clock-enable tick.
// Rev    : 1.0
// ============================================================================
module nexys4ddr_display_mux #(
    parameter int unsigned FREQ     = 32'd100_000_000,
    parameter int unsigned REFRESH  = 1200,
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned BRIGHT_W = 4,
    parameter bit          AN_LOW   = 1'b1,
    parameter bit          SEG_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*7-1:0]   raw_segs,
    input  logic [DIGITS*4-1:0]   hex_vals,
    input  logic [DIGITS-1:0]     hex_mode,
    input  logic [DIGITS-1:0]     decpoints,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  update,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned DIV_RAW = FREQ / (REFRESH * DIGITS);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  SLOT_RELOAD = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_INV      = AN_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_INV     = SEG_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_INV      = SEG_LOW;

    function automatic logic [6:0] hexdec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]    slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;
    logic                pending_q, pending_d;
    logic [DIGITS*7-1:0] sh_raw_q, sh_raw_d;
    logic [DIGITS*4-1:0] sh_hex_q, sh_hex_d;
    logic [DIGITS-1:0]   sh_mode_q, sh_mode_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_en_q, sh_en_d;
    logic [BRIGHT_W-1:0] sh_bright_q, sh_bright_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic                tick, wrap, load, lit;
    int unsigned         sel;
    logic [DIGITS*7-1:0] raw_sh;
    logic [DIGITS*4-1:0] hex_sh;
    logic [DIGITS-1:0]   mode_sh, dp_sh, en_sh;
    logic [DIGITS-1:0]   an_int;
    logic [6:0]          seg_int;
    logic                dp_int;

    always_comb begin
        tick = (slot_q == '0);
        wrap = tick && (idx_q == IDX_LAST);

        slot_d = tick ? SLOT_RELOAD : slot_q - 1'b1;
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        pwm_d = pwm_q + 1'b1;

        // Shadow only changes on the frame boundary so a frame never mixes old and new data
        load      = wrap && (pending_q || update);
        pending_d = load ? 1'b0 : (pending_q || update);

        sh_raw_d    = load ? raw_segs   : sh_raw_q;
        sh_hex_d    = load ? hex_vals   : sh_hex_q;
        sh_mode_d   = load ? hex_mode   : sh_mode_q;
        sh_dp_d     = load ? decpoints  : sh_dp_q;
        sh_en_d     = load ? digit_en   : sh_en_q;
        sh_bright_d = load ? brightness : sh_bright_q;

        sel     = 32'(idx_q);
        raw_sh  = sh_raw_q >> (7 * sel);
        hex_sh  = sh_hex_q >> (4 * sel);
        mode_sh = sh_mode_q >> idx_q;
        dp_sh   = sh_dp_q >> idx_q;
        en_sh   = sh_en_q >> idx_q;

        lit     = en_sh[0] && (pwm_q <= sh_bright_q);
        an_int  = lit ? (DIGITS'(1) << idx_q) : '0;
        seg_int = en_sh[0] ? (mode_sh[0] ? hexdec(hex_sh[3:0]) : raw_sh[6:0]) : 7'h00;
        dp_int  = en_sh[0] && dp_sh[0];

        an_d         = an_int ^ AN_INV;
        seg_d        = seg_int ^ SEG_INV;
        dp_d         = dp_int ^ DP_INV;
        frame_done_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q       <= SLOT_RELOAD;
            idx_q        <= '0;
            pwm_q        <= '0;
            pending_q    <= 1'b0;
            sh_raw_q     <= '0;
            sh_hex_q     <= '0;
            sh_mode_q    <= '0;
            sh_dp_q      <= '0;
            sh_en_q      <= '0;
            sh_bright_q  <= '0;
            seg_q        <= SEG_INV;
            dp_q         <= DP_INV;
            an_q         <= AN_INV;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            pending_q    <= pending_d;
            sh_raw_q     <= sh_raw_d;
            sh_hex_q     <= sh_hex_d;
            sh_mode_q    <= sh_mode_d;
            sh_dp_q      <= sh_dp_d;
            sh_en_q      <= sh_en_d;
            sh_bright_q  <= sh_bright_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
